// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the two-master memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } arb_state_t;

    typedef logic master_idx_t;

    localparam master_idx_t c_master0       = 1'b0;
    localparam master_idx_t c_master1       = 1'b1;
    localparam logic [31:0] c_timeout_rdata = 32'h0000_0000;

    // Watchdog counter width: enough bits to hold TIMEOUT_CYCLES itself.
    function automatic int wdog_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_wdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_wdog
// Description : Saturating stall counter; flags the TIMEOUT_CYCLES-th stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_wdog
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int c_width = wdog_width(TIMEOUT_CYCLES);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset, clear, count_en};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam logic [c_width-1:0] c_one  = c_width'(1);
            localparam logic [c_width-1:0] c_last = c_width'(TIMEOUT_CYCLES - 1);
            localparam logic [c_width-1:0] c_sat  = c_width'(TIMEOUT_CYCLES);

            logic [c_width-1:0] r_count;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    r_count <= '0;
                end else if (count_en && (r_count != c_sat)) begin
                    r_count <= r_count + c_one;
                end
            end

            // Counter holds the number of earlier stalls, so the Nth stall sees N-1.
            assign expired = count_en && (r_count == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master to one-slave native-bus arbiter with stall timeout.
//               Define MEM_ARBITER_RR_EN for round-robin; default is m0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        timeout
);

    arb_state_t  r_state;
    master_idx_t w_pick;
    logic        w_any_req;
    logic        w_gnt_valid;
    logic        w_done;
    logic        w_expired;
    logic        w_force;
    logic        w_busy0;
    logic        w_busy1;

`ifdef MEM_ARBITER_RR_EN
    master_idx_t r_last;
`endif

    assign w_any_req = m0_valid | m1_valid;
    assign w_busy0   = (r_state == ST_BUSY0);
    assign w_busy1   = (r_state == ST_BUSY1);

    always_comb begin
        w_pick = c_master0;
`ifdef MEM_ARBITER_RR_EN
        if (m0_valid && m1_valid) begin
            w_pick = (r_last == c_master1) ? c_master0 : c_master1;
        end else if (!m0_valid) begin
            w_pick = c_master1;
        end
`else
        if (!m0_valid) begin
            w_pick = c_master1;
        end
`endif
    end

    // Slave-side mux; forced quiet while reset is asserted so nothing leaks out.
    always_comb begin
        w_gnt_valid = 1'b0;
        s_instr     = 1'b0;
        s_addr      = 32'h0;
        s_wdata     = 32'h0;
        s_wstrb     = 4'h0;
        if (!reset) begin
            case (r_state)
                ST_BUSY0: begin
                    w_gnt_valid = m0_valid;
                    s_instr     = m0_instr;
                    s_addr      = m0_addr;
                    s_wdata     = m0_wdata;
                    s_wstrb     = m0_wstrb;
                end
                ST_BUSY1: begin
                    w_gnt_valid = m1_valid;
                    s_instr     = m1_instr;
                    s_addr      = m1_addr;
                    s_wdata     = m1_wdata;
                    s_wstrb     = m1_wstrb;
                end
                default: ;
            endcase
        end
    end

    assign s_valid = w_gnt_valid;
    assign w_done  = w_gnt_valid & s_ready;
    // Expiry only fires while the master still waits and the slave is stalled.
    assign w_force = w_expired;
    assign timeout = w_force;

    assign m0_ready = w_busy0 & (w_done | w_force);
    assign m1_ready = w_busy1 & (w_done | w_force);
    assign m0_rdata = (w_busy0 && w_done) ? s_rdata : c_timeout_rdata;
    assign m1_rdata = (w_busy1 && w_done) ? s_rdata : c_timeout_rdata;

    mem_arbiter_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (r_state == ST_IDLE),
        .count_en (w_gnt_valid & ~s_ready),
        .expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
`ifdef MEM_ARBITER_RR_EN
            r_last  <= c_master1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= (w_pick == c_master0) ? ST_BUSY0 : ST_BUSY1;
`ifdef MEM_ARBITER_RR_EN
                        r_last  <= w_pick;
`endif
                    end
                end
                ST_BUSY0, ST_BUSY1: begin
                    if (!w_gnt_valid || w_done || w_force) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed scoreboard bench for mem_arbiter (TIMEOUT_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        timeout;

    typedef struct {
        logic        m;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        tout;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_checks = 0;
    int   n_err    = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic m, input logic [31:0] addr, input logic [31:0] rdata,
                        input logic tout);
        exp_t x;
        x.m = m; x.addr = addr; x.rdata = rdata; x.tout = tout;
        sbq.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completion must match the head of the scoreboard.
    always @(negedge clk) begin
        if (m0_ready || m1_ready) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_ready: got m0_ready=%b m1_ready=%b expected none",
                         m0_ready, m1_ready);
            end else begin
                e = sbq.pop_front();
                chk("both_ready", {31'b0, m0_ready & m1_ready}, 32'h0);
                chk("grant_master", {31'b0, m1_ready}, {31'b0, e.m});
                chk("done_addr", s_addr, e.addr);
                chk("done_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
                chk("loser_rdata", e.m ? m0_rdata : m1_rdata, 32'h0);
                chk("done_timeout", {31'b0, timeout}, {31'b0, e.tout});
            end
        end else if (timeout) begin
            n_checks++;
            n_err++;
            $display("FAIL stray_timeout: got timeout=1 expected 0 without ready");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
        tick; tick;
        @(negedge clk);
        chk("rst_s_valid", {31'b0, s_valid}, 32'h0);
        chk("rst_readys", {30'b0, m0_ready, m1_ready}, 32'h0);
        chk("rst_timeout", {31'b0, timeout}, 32'h0);
        tick;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_addr", s_addr, 32'h0);

        // Single m0 read, slave answers in the second BUSY cycle
        tick;
        m0_valid = 1; m0_instr = 0; m0_addr = 32'h100;
        push(1'b0, 32'h100, 32'h1234_5678, 1'b0);
        tick;
        @(negedge clk);
        chk("busy0_s_valid", {31'b0, s_valid}, 32'h1);
        chk("busy0_s_addr", s_addr, 32'h100);
        chk("busy0_m1_ready", {31'b0, m1_ready}, 32'h0);
        tick;
        s_ready = 1; s_rdata = 32'h1234_5678;
        tick;
        m0_valid = 0; s_ready = 0; s_rdata = 0;
        @(negedge clk);
        chk("idle_after_read", {31'b0, s_valid}, 32'h0);

        // Reset in the middle of a BUSY0 transfer
        tick;
        m0_valid = 1; m0_addr = 32'h180;
        tick;
        @(negedge clk);
        chk("pre_rst_s_valid", {31'b0, s_valid}, 32'h1);
        reset = 1'b1;
        tick;
        reset = 1'b0; m0_valid = 0;
        @(negedge clk);
        chk("midrst_s_valid", {31'b0, s_valid}, 32'h0);
        chk("midrst_m0_ready", {31'b0, m0_ready}, 32'h0);
        chk("midrst_timeout", {31'b0, timeout}, 32'h0);

        // Contention: both masters request continuously, slave always ready
        tick;
        m0_addr = 32'h200; m1_addr = 32'h300;
        m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'hA5A5_5A5A;
`ifdef MEM_ARBITER_RR_EN
        push(1'b0, 32'h200, 32'hA5A5_5A5A, 1'b0);
        push(1'b1, 32'h300, 32'hA5A5_5A5A, 1'b0);
        push(1'b0, 32'h200, 32'hA5A5_5A5A, 1'b0);
        push(1'b1, 32'h300, 32'hA5A5_5A5A, 1'b0);
        repeat (8) tick;
        m0_valid = 0; m1_valid = 0;
`else
        for (int i = 0; i < 4; i++) push(1'b0, 32'h200, 32'hA5A5_5A5A, 1'b0);
        push(1'b1, 32'h300, 32'hA5A5_5A5A, 1'b0);
        repeat (8) tick;
        m0_valid = 0;
        repeat (2) tick;
        m1_valid = 0;
`endif
        s_ready = 0; s_rdata = 0;

        // m1 write with slave stalled: forced completion on the 4th BUSY cycle
        tick;
        m1_valid = 1; m1_instr = 0; m1_addr = 32'h400; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
        push(1'b1, 32'h400, 32'h0, 1'b1);
        tick;
        @(negedge clk);
        chk("busy1_s_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("busy1_s_wstrb", {28'b0, s_wstrb}, 32'hF);
        chk("busy1_early_timeout", {31'b0, timeout}, 32'h0);
        repeat (4) tick;
        m1_valid = 0;
        @(negedge clk);
        chk("idle_after_timeout", {31'b0, s_valid}, 32'h0);

        // s_ready arrives exactly on the 4th BUSY cycle: normal completion
        tick;
        m0_valid = 1; m0_addr = 32'h500;
        push(1'b0, 32'h500, 32'hCAFE_F00D, 1'b0);
        repeat (4) tick;
        s_ready = 1; s_rdata = 32'hCAFE_F00D;
        tick;
        s_ready = 0; s_rdata = 0; m0_valid = 0;

        // m1 abandons its request before the slave answers
        tick;
        m1_valid = 1; m1_addr = 32'h600;
        tick;
        m1_valid = 0;
        @(negedge clk);
        chk("abandon_m1_ready", {31'b0, m1_ready}, 32'h0);
        chk("abandon_s_valid", {31'b0, s_valid}, 32'h0);
        tick;
        @(negedge clk);
        chk("abandon_idle_s_addr", s_addr, 32'h0);

        repeat (3) tick;
        chk("scoreboard_empty", sbq.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
